audio_recorder: RTL
===================

# audio_recorder

Capture-side counterpart of the ROM playback path. Waits for an armed trigger on the incoming 8-bit sample stream, then writes a programmed number of consecutive samples into an internal sample RAM. The RAM's synchronous read port is exposed so a playback driver can read the recording back. Sits between the ADC/sample source and the playback logic, sharing its single clock.

## Interface
- ADDR_W, 8, RAM address width; depth = 2^ADDR_W samples
- DATA_W, 8, sample width
- MID, 8'h80, unsigned midscale used for trigger magnitude
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  sample strobe; audio_in valid when high
- audio_in  in  DATA_W  unsigned sample
- start  in  1  one-cycle pulse: clear and arm
- abort  in  1  one-cycle pulse: return to IDLE
- threshold  in  DATA_W  trigger level, sampled when used
- length  in  ADDR_W+1  samples to record, 0..2^ADDR_W, latched on start
- armed  out  1  high in ARMED
- busy  out  1  high in ARMED or RECORD
- done  out  1  high in DONE, held until next start/abort
- count  out  ADDR_W+1  samples written this recording
- rd_addr  in  ADDR_W  playback read address
- rd_data  out  DATA_W  RAM data for rd_addr, one cycle later

## Operation
- States: IDLE, ARMED, RECORD, DONE.
- IDLE/DONE + start: count<=0, done<=0, len latched; len==0 -> DONE, else -> ARMED. start in ARMED/RECORD ignored.
- ARMED: on ena cycle compute mag = |audio_in - MID| in DATA_W+1 bits; mag > threshold (strict) triggers. Triggering sample written to address 0 on the same edge, count<=1; -> DONE if len==1, else -> RECORD. Non-trigger ena cycles write nothing.
- RECORD: each ena cycle writes audio_in at address count[ADDR_W-1:0], count<=count+1; when count+1 == len -> DONE. ena low: hold. No wrap: len==2^ADDR_W fills addresses 0..2^ADDR_W-1 exactly once.
- DONE: no writes; count holds final value.
- abort from any state -> IDLE next edge, no write that cycle, count holds, done<=0. abort and start same cycle: abort wins.
- RAM write port owned solely by this block; RAM contents not reset.

## Timing
- Reset values: state IDLE, armed 0, busy 0, done 0, count 0, rd_data 0.
- Reset asserted mid-recording: immediate return to IDLE; already-written RAM words remain.
- armed/busy asserted the cycle after start is sampled.
- Last sample write and done rise on the same edge; done/count registered, no combinational path from inputs to outputs.
- Read latency 1 cycle; read and write to same address on one edge returns the old word (read-before-write).
- Trigger decision uses audio_in and threshold of the triggering cycle only; no pipeline delay between trigger sample and its write.

## Structure
- Shared package audio_pkg: state enum (IDLE/ARMED/RECORD/DONE), MID default, sample/address width constants used by both playback and capture blocks.
- One sub-module: sample_ram (1 write port, 1 synchronous read port, DATA_W x 2^ADDR_W, read-before-write).
- Control FSM, counter and trigger compare live in audio_recorder.

## Test plan
- Reset: hold rst_n low mid-RECORD -> all outputs at reset values asynchronously, FSM in IDLE after release.
- Basic capture: threshold=16, length=4, feed ena every cycle 8'h80,8'h85,8'hA0,8'h11,8'h22,8'h33,8'h44 -> trigger on 8'hA0; RAM[0..3]=A0,11,22,33; done=1, count=4; 8'h44 not written.
- Threshold boundary: threshold=16, sample 8'h90 (mag 16) no trigger; 8'h6F (mag 17) triggers.
- Gapped ena and full depth: length=256, ena every third cycle -> 256 writes, addresses 0..255, no wrap, count=256, no further writes after done.
- Edge lengths: length=0 -> done one cycle after start, no writes; length=1 -> done on trigger edge.
- Control races: start during RECORD ignored; abort+start same cycle -> IDLE, done 0; read of address being written returns old word.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and capture FSM state type, common to playback and capture.
package audio_pkg;

    // Default sample and RAM address widths used across the audio path
    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned REC_ADDR_W = 8;

    // Unsigned midscale: the zero point of an offset-binary sample
    localparam logic [7:0] MID_DEFAULT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RECORD = 2'd2,
        ST_DONE   = 2'd3
    } rec_state_e;

endpackage

// File: rtl/sample_ram.sv
// Single-clock sample RAM: one write port, one registered read port, read-before-write.
module sample_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register samples the array before any same-edge write lands
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_recorder.sv
// Triggered sample capture: arms on start, waits for |sample - MID| > threshold,
// then stores a programmed number of consecutive strobed samples into sample_ram.
module audio_recorder
    import audio_pkg::*;
#(
    parameter int unsigned       ADDR_W = REC_ADDR_W,
    parameter int unsigned       DATA_W = SAMPLE_W,
    parameter logic [DATA_W-1:0] MID    = DATA_W'(MID_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ena,
    input  logic [DATA_W-1:0] i_audio_in,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_threshold,
    input  logic [ADDR_W:0]   i_length,
    output logic              o_armed,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_count,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    rec_state_e        r_state;
    logic              r_armed;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_len;

    logic [DATA_W:0]   w_mag;
    logic              w_trig;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;

    // Distance of the current sample from midscale, one bit wider than a sample
    always_comb begin
        if (i_audio_in >= MID) begin
            w_mag = {1'b0, i_audio_in - MID};
        end else begin
            w_mag = {1'b0, MID - i_audio_in};
        end
    end

    assign w_trig    = i_ena && (w_mag > {1'b0, i_threshold});
    assign w_cnt_inc = r_count + 1'b1;

    // RAM write strobe: trigger sample goes to address 0 on its own edge, no pipelining
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_count[ADDR_W-1:0];
        if (!i_abort) begin
            if (r_state == ST_ARMED && w_trig) begin
                w_we    = 1'b1;
                w_waddr = '0;
            end else if (r_state == ST_RECORD && i_ena) begin
                w_we = 1'b1;
            end
        end
    end

    // Control FSM with registered status outputs and sample counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_len   <= '0;
        end else if (i_abort) begin
            // Abort beats start and freezes the count for inspection
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_count <= '0;
                        r_len   <= i_length;
                        if (i_length == '0) begin
                            r_state <= ST_DONE;
                            r_armed <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ARMED;
                            r_armed <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        r_count <= LEN_ONE;
                        r_armed <= 1'b0;
                        if (r_len == LEN_ONE) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RECORD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RECORD: begin
                    if (i_ena) begin
                        r_count <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_armed <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_armed = r_armed;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_count = r_count;

    sample_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sample_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_audio_in),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

endmodule
